eth_tx_arbiter: RTL and testbench

- Shares the single GMII TX header/frame path between two requesters: the ARP reply engine and the IPv4 transmit engine.
- Grants one requester at a time with round-robin fairness and drives the frame-start strobe and EtherType to the TX header generator.
- Holds the grant until the MAC reports end of frame, then enforces the inter-frame gap before the next grant.
- Sits between the ARP/IP TX engines and the MAC TX header block, in the mac_gmii_tx_clk domain.

---
 rtl/eth_tx_arbiter_if.sv | 43 ++++
 rtl/eth_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_if.sv
// Handshake bundle between the ARP/IP TX engines, the MAC TX header block and eth_tx_arbiter.
// master = arbiter side, slave = engines/MAC side.
interface eth_tx_arbiter_if;
    logic        arp_tx_req;
    logic        arp_tx_gnt;
    logic        arp_tx_done;
    logic        ip_tx_req;
    logic        ip_tx_gnt;
    logic        ip_tx_done;
    logic        tx_start;
    logic [15:0] tx_eth_type;
    logic        mac_tx_done;
    logic        tx_abort;
    logic        timeout_err;

    modport master (
        input  arp_tx_req,
        input  ip_tx_req,
        input  mac_tx_done,
        output arp_tx_gnt,
        output arp_tx_done,
        output ip_tx_gnt,
        output ip_tx_done,
        output tx_start,
        output tx_eth_type,
        output tx_abort,
        output timeout_err
    );

    modport slave (
        output arp_tx_req,
        output ip_tx_req,
        output mac_tx_done,
        input  arp_tx_gnt,
        input  arp_tx_done,
        input  ip_tx_gnt,
        input  ip_tx_done,
        input  tx_start,
        input  tx_eth_type,
        input  tx_abort,
        input  timeout_err
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing the GMII TX header path between the ARP and IPv4 TX engines.
// Define ETH_TX_ARP_PRIORITY_EN to make ARP win every simultaneous request (fixed priority).
module eth_tx_arbiter #(
    parameter int unsigned IFG_CYCLES     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 2048,
    parameter logic [15:0] ETH_ARP_TYPE   = 16'h0806,
    parameter logic [15:0] ETH_IP_TYPE    = 16'h0800
) (
    input logic              mac_gmii_tx_clk,
    input logic              mac_gmii_tx_rst,
    eth_tx_arbiter_if.master bus
);
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_IFG    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_ARP = 1'b0,
        OWN_IP  = 1'b1
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic [15:0]       eth_type_q, eth_type_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [IFG_W-1:0]  ifg_cnt_q, ifg_cnt_d;
    logic              arp_gnt_q, arp_gnt_d;
    logic              ip_gnt_q, ip_gnt_d;
    logic              arp_done_q, arp_done_d;
    logic              ip_done_q, ip_done_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;

    logic              any_req_s;
    owner_e            winner_s;

    // Pick the requester that would be granted if the arbiter is in IDLE this cycle
    always_comb begin
        any_req_s = bus.arp_tx_req | bus.ip_tx_req;
`ifdef ETH_TX_ARP_PRIORITY_EN
        if (bus.arp_tx_req) begin
            winner_s = OWN_ARP;
        end else begin
            winner_s = OWN_IP;
        end
`else
        if (bus.arp_tx_req && bus.ip_tx_req) begin
            // On a tie, the requester that did not finish the previous frame wins.
            winner_s = (last_owner_q == OWN_IP) ? OWN_ARP : OWN_IP;
        end else if (bus.arp_tx_req) begin
            winner_s = OWN_ARP;
        end else begin
            winner_s = OWN_IP;
        end
`endif
    end

    // Next-state and next-output logic for the grant FSM
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        eth_type_d   = eth_type_q;
        to_cnt_d     = to_cnt_q;
        ifg_cnt_d    = ifg_cnt_q;
        arp_gnt_d    = 1'b0;
        ip_gnt_d     = 1'b0;
        arp_done_d   = 1'b0;
        ip_done_d    = 1'b0;
        start_d      = 1'b0;
        abort_d      = 1'b0;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    owner_d    = winner_s;
                    eth_type_d = (winner_s == OWN_ARP) ? ETH_ARP_TYPE : ETH_IP_TYPE;
                    start_d    = 1'b1;
                    arp_gnt_d  = (winner_s == OWN_ARP);
                    ip_gnt_d   = (winner_s == OWN_IP);
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                to_cnt_d  = '0;
                arp_gnt_d = (owner_q == OWN_ARP);
                ip_gnt_d  = (owner_q == OWN_IP);
                state_d   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.mac_tx_done) begin
                    // Frame end beats a coincident timeout expiry.
                    arp_done_d   = (owner_q == OWN_ARP);
                    ip_done_d    = (owner_q == OWN_IP);
                    last_owner_d = owner_q;
                    ifg_cnt_d    = '0;
                    state_d      = ST_IFG;
                end else if (to_cnt_q == TO_LAST) begin
                    arp_done_d = (owner_q == OWN_ARP);
                    ip_done_d  = (owner_q == OWN_IP);
                    abort_d    = 1'b1;
                    err_d      = 1'b1;
                    ifg_cnt_d  = '0;
                    state_d    = ST_IFG;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
                    arp_gnt_d = (owner_q == OWN_ARP);
                    ip_gnt_d  = (owner_q == OWN_IP);
                    state_d   = ST_ACTIVE;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                    state_d   = ST_IFG;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
        if (mac_gmii_tx_rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_ARP;
            last_owner_q <= OWN_IP;
            eth_type_q   <= 16'h0000;
            to_cnt_q     <= '0;
            ifg_cnt_q    <= '0;
            arp_gnt_q    <= 1'b0;
            ip_gnt_q     <= 1'b0;
            arp_done_q   <= 1'b0;
            ip_done_q    <= 1'b0;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            eth_type_q   <= eth_type_d;
            to_cnt_q     <= to_cnt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            arp_gnt_q    <= arp_gnt_d;
            ip_gnt_q     <= ip_gnt_d;
            arp_done_q   <= arp_done_d;
            ip_done_q    <= ip_done_d;
            start_q      <= start_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
        end
    end

    assign bus.arp_tx_gnt  = arp_gnt_q;
    assign bus.ip_tx_gnt   = ip_gnt_q;
    assign bus.arp_tx_done = arp_done_q;
    assign bus.ip_tx_done  = ip_done_q;
    assign bus.tx_start    = start_q;
    assign bus.tx_eth_type = eth_type_q;
    assign bus.tx_abort    = abort_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized self-checking bench for eth_tx_arbiter against a frame-level reference model.
module tb_eth_tx_arbiter;
    localparam int IFG     = 12;
    localparam int TIMEOUT = 2048;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    // Reference model state: who finished the last frame, sticky error, timing anchors.
    bit   last_owner_ip_m;
    bit   te_m;
    bit   have_done;
    int   last_done_cyc;
    int   req_cyc;
    bit   grant_log[$];

    eth_tx_arbiter_if bus_if ();

    eth_tx_arbiter #(
        .IFG_CYCLES    (IFG),
        .TIMEOUT_CYCLES(TIMEOUT),
        .ETH_ARP_TYPE  (16'h0806),
        .ETH_IP_TYPE   (16'h0800)
    ) dut (
        .mac_gmii_tx_clk(clk),
        .mac_gmii_tx_rst(rst),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Grants must never overlap.
    always @(negedge clk) check("gnt_mutex", {31'd0, bus_if.arp_tx_gnt & bus_if.ip_tx_gnt}, 32'd0);

    function automatic bit model_arp_wins(input bit a, input bit i);
`ifdef ETH_TX_ARP_PRIORITY_EN
        return a;
`else
        if (a && i) return last_owner_ip_m;
        return a;
`endif
    endfunction

    // One arbitration + frame. done_at: ACTIVE cycle (1-based) carrying mac_tx_done, 0 = never.
    // Afterwards the next request pattern is applied: held from the done cycle (idle_w == 0)
    // or after idle_w quiet cycles.
    task automatic run_frame(input int done_at, input bit mtd_in_start, input bit drop_req,
                             input bit nxt_arp, input bit nxt_ip, input int idle_w);
        bit own_arp;
        bit found;
        bit timed_out;
        int exp_start;
        int end_n;
        own_arp   = model_arp_wins(bus_if.arp_tx_req, bus_if.ip_tx_req);
        exp_start = req_cyc + 1;
        if (have_done && (last_done_cyc + IFG + 1 > exp_start)) exp_start = last_done_cyc + IFG + 1;
        found = 1'b0;
        for (int w = 0; w < 64 && !found; w++) begin
            @(negedge clk);
            if (bus_if.tx_start === 1'b1) begin
                found = 1'b1;
            end else begin
                check("wait_gnt", {30'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt}, 32'd0);
                check("wait_done", {30'd0, bus_if.arp_tx_done, bus_if.ip_tx_done}, 32'd0);
            end
        end
        if (!found) begin
            check("start_seen", 32'd0, 32'd1);
            return;
        end
        check("start_cycle", cyc, exp_start);
        check("start_gnt", {30'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt}, own_arp ? 32'd2 : 32'd1);
        check("eth_type", {16'd0, bus_if.tx_eth_type}, own_arp ? 32'h0806 : 32'h0800);
        check("start_done", {30'd0, bus_if.arp_tx_done, bus_if.ip_tx_done}, 32'd0);
        grant_log.push_back(own_arp);
        bus_if.mac_tx_done = mtd_in_start;

        timed_out = !((done_at > 0) && (done_at <= TIMEOUT));
        end_n     = timed_out ? TIMEOUT : done_at;
        for (int n = 1; n <= end_n; n++) begin
            @(negedge clk);
            check("act_gnt", {30'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt}, own_arp ? 32'd2 : 32'd1);
            check("act_start", {31'd0, bus_if.tx_start}, 32'd0);
            check("act_done", {30'd0, bus_if.arp_tx_done, bus_if.ip_tx_done}, 32'd0);
            check("act_abort", {31'd0, bus_if.tx_abort}, 32'd0);
            check("act_err", {31'd0, bus_if.timeout_err}, {31'd0, te_m});
            bus_if.mac_tx_done = (n == done_at);
            if (n == 1 && drop_req) begin
                if (own_arp) bus_if.arp_tx_req = 1'b0;
                else         bus_if.ip_tx_req  = 1'b0;
            end
        end

        @(negedge clk);
        bus_if.mac_tx_done = 1'b0;
        check("done_pulse", {30'd0, bus_if.arp_tx_done, bus_if.ip_tx_done}, own_arp ? 32'd2 : 32'd1);
        check("done_gnt", {30'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt}, 32'd0);
        check("done_abort", {31'd0, bus_if.tx_abort}, {31'd0, timed_out});
        if (timed_out) te_m = 1'b1;
        else           last_owner_ip_m = !own_arp;
        check("done_err", {31'd0, bus_if.timeout_err}, {31'd0, te_m});
        have_done     = 1'b1;
        last_done_cyc = cyc;

        if (idle_w == 0) begin
            bus_if.arp_tx_req = nxt_arp;
            bus_if.ip_tx_req  = nxt_ip;
            req_cyc = cyc;
        end else begin
            bus_if.arp_tx_req = 1'b0;
            bus_if.ip_tx_req  = 1'b0;
            for (int i = 0; i < idle_w; i++) begin
                @(negedge clk);
                check("idle_gnt", {30'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt}, 32'd0);
                check("idle_done", {30'd0, bus_if.arp_tx_done, bus_if.ip_tx_done}, 32'd0);
                check("idle_start", {31'd0, bus_if.tx_start}, 32'd0);
                check("idle_abort", {31'd0, bus_if.tx_abort}, 32'd0);
                // Stray MAC done pulses outside ACTIVE must be ignored.
                bus_if.mac_tx_done = (i == idle_w - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            bus_if.arp_tx_req = nxt_arp;
            bus_if.ip_tx_req  = nxt_ip;
            req_cyc = cyc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {23'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt, bus_if.arp_tx_done, bus_if.ip_tx_done,
                    bus_if.tx_start, bus_if.tx_abort, bus_if.timeout_err, 2'd0}, 32'd0);
        check({tag, "_type"}, {16'd0, bus_if.tx_eth_type}, 32'd0);
    endtask

    initial begin
        bit exp_seq[4];
        bit found;
        int pat;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus_if.arp_tx_req  = 1'b0;
        bus_if.ip_tx_req   = 1'b0;
        bus_if.mac_tx_done = 1'b0;
        last_owner_ip_m = 1'b1;
        te_m            = 1'b0;
        have_done       = 1'b0;
        last_done_cyc   = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        // Both requests held out of reset: alternation under round robin.
        bus_if.arp_tx_req = 1'b1;
        bus_if.ip_tx_req  = 1'b1;
        req_cyc = cyc;
        run_frame(5, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        run_frame(3, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        run_frame(8, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_frame(1, 1'b0, 1'b0, 1'b1, 1'b0, 15);
`ifdef ETH_TX_ARP_PRIORITY_EN
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 4; i++) check("tie_order", {31'd0, grant_log[i]}, {31'd0, exp_seq[i]});

        // Single ARP request from idle (1-cycle latency checked inside), then randomized frames.
        for (int f = 0; f < 40; f++) begin
            pat = (f == 39) ? 1 : int'($urandom_range(1, 3));
            run_frame(int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      pat[1], pat[0], ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20)));
        end

        // mac_tx_done on the last timeout cycle: normal completion, no error.
        run_frame(TIMEOUT, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("race_err", {31'd0, bus_if.timeout_err}, 32'd0);

        // Timeout on an IP frame, then recovery with a following ARP frame.
        run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_frame(4, 1'b0, 1'b0, 1'b1, 1'b0, 15);
        check("err_sticky", {31'd0, bus_if.timeout_err}, 32'd1);

        // Reset in the middle of a frame.
        found = 1'b0;
        for (int w = 0; w < 64 && !found; w++) begin
            @(negedge clk);
            if (bus_if.tx_start === 1'b1) found = 1'b1;
        end
        check("rst_frame_start", {31'd0, found}, 32'd1);
        repeat (3) @(negedge clk);
        check("rst_pre_gnt", {31'd0, bus_if.arp_tx_gnt}, 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_async_gnt", {30'd0, bus_if.arp_tx_gnt, bus_if.ip_tx_gnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("rst_hold");
        end
        rst = 1'b0;
        last_owner_ip_m = 1'b1;
        te_m            = 1'b0;
        have_done       = 1'b0;
        bus_if.arp_tx_req = 1'b1;
        bus_if.ip_tx_req  = 1'b1;
        req_cyc = cyc;
        grant_log.delete();
        run_frame(6, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        check("post_rst_arp_first", (grant_log.size() > 0) ? {31'd0, grant_log[0]} : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
